// File: rtl/acq_sequencer.sv
// acq_sequencer
//   Sequences one acquisition run of the processing datapath for the soft
//   processor. A rising edge on start pulses the datapath reset for
//   max(clear_cycles,1) cycles. It then enables the datapath and counts
//   result_valid strobes up to num_results. Next it waits for calc_done, and
//   finally reports done. abort returns the sequencer to IDLE from any state.
//
//   Optional feature (macro ACQ_SEQUENCER_WATCHDOG_EN): adds a watchdog that
//   ends a stuck RUN/DRAIN phase after timeout_cycles cycles and raises error.
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high reset
//   start           level; a rising edge requests a run
//   abort           level; forces IDLE while high
//   num_results     result strobes to collect per run
//   clear_cycles    datapath reset pulse length (0 treated as 1)
//   result_valid    one-cycle strobe per datapath result
//   calc_done       datapath calculation-finished flag
//   timeout_cycles  watchdog limit, 0 disables (watchdog build only)
//   error           watchdog expired in the last run (watchdog build only)
//   dp_enable       datapath enable
//   dp_reset        datapath/FIFO reset, active-high
//   busy            high in CLEAR, RUN, DRAIN
//   done            high in DONE until the next start or abort
//   result_count    results counted in the current or last run
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a start edge
// CLEAR | datapath held in reset for max(clear_cycles,1) cycles
// RUN   | datapath enabled, counting result strobes
// DRAIN | datapath disabled, waiting for calc_done
// DONE  | run finished, done reported, count held

module acq_sequencer #(
  parameter int CNT_W = 32,
  parameter int CLR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_results,
  input  logic [CLR_W-1:0] clear_cycles,
  input  logic             result_valid,
  input  logic             calc_done,
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
  input  logic [31:0]      timeout_cycles,
  output logic             error,
`endif
  output logic             dp_enable,
  output logic             dp_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CLR_W:0]   CLR_ONE = (CLR_W+1)'(1);

  state_t           state, state_nxt;
  logic             start_d;
  logic             start_pulse;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [CLR_W:0]   clr_len;
  logic             clr_last;
  logic [CNT_W-1:0] count_inc, count_nxt;

  assign start_pulse = start & ~start_d;

  // clr_cnt counts CLEAR cycles already spent; one extra bit keeps the
  // compare exact when clear_cycles is at its maximum.
  assign clr_len   = (clear_cycles == '0) ? CLR_ONE : {1'b0, clear_cycles};
  assign clr_last  = (({1'b0, clr_cnt} + CLR_ONE) >= clr_len);
  assign count_inc = result_count + CNT_ONE;

`ifdef ACQ_SEQUENCER_WATCHDOG_EN
  logic [31:0] wd_cnt, wd_cnt_nxt;
  logic        wd_hit;
  logic        err_nxt;

  // Fires on the timeout_cycles-th cycle spent in RUN/DRAIN.
  assign wd_hit = (timeout_cycles != 32'd0) &&
                  (({1'b0, wd_cnt} + 33'd1) >= {1'b0, timeout_cycles});
`endif

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    count_nxt   = result_count;
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
    wd_cnt_nxt  = wd_cnt;
    err_nxt     = error;
`endif
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_pulse) begin
            state_nxt   = S_CLEAR;
            clr_cnt_nxt = '0;
            count_nxt   = '0;
          end
        end
        S_CLEAR: begin
          if (clr_last) begin
            state_nxt = (num_results == '0) ? S_DRAIN : S_RUN;
          end else begin
            clr_cnt_nxt = clr_cnt + CLR_W'(1);
          end
        end
        S_RUN: begin
          if (result_valid) begin
            count_nxt = count_inc;
            if (count_inc == num_results) begin
              state_nxt = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (calc_done) begin
            state_nxt = S_DONE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
      if (state == S_CLEAR) begin
        wd_cnt_nxt = '0;
      end else if (state == S_RUN || state == S_DRAIN) begin
        wd_cnt_nxt = wd_cnt + 32'd1;
        if (wd_hit) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      if (state_nxt == S_CLEAR) begin
        err_nxt = 1'b0;
      end
`endif
    end
  end

  // Outputs are decoded from the next state so they are valid in the same
  // cycle the state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      start_d      <= 1'b0;
      clr_cnt      <= '0;
      result_count <= '0;
      dp_enable    <= 1'b0;
      dp_reset     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
      wd_cnt       <= '0;
      error        <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      start_d      <= start;
      clr_cnt      <= clr_cnt_nxt;
      result_count <= count_nxt;
      dp_reset     <= (state_nxt == S_CLEAR);
      dp_enable    <= (state_nxt == S_RUN);
      busy         <= (state_nxt == S_CLEAR) || (state_nxt == S_RUN) ||
                      (state_nxt == S_DRAIN);
      done         <= (state_nxt == S_DONE);
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
      wd_cnt       <= wd_cnt_nxt;
      error        <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer
//   Self-checking bench for acq_sequencer. Each run is described by a few
//   numbers: clear length, result count, extra strobes, calc_done offset, and
//   an optional abort/reset cycle. From these numbers the expected waveform
//   follows arithmetically: the CLEAR window, the RUN window up to the n-th
//   strobe, the done cycle, and the running count.
//   Watchdog tests are compiled in when ACQ_SEQUENCER_WATCHDOG_EN is defined.

module tb_acq_sequencer;

  localparam int CNT_W = 32;
  localparam int CLR_W = 8;
  localparam int MAXC  = 96;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_results;
  logic [CLR_W-1:0] clear_cycles;
  logic             result_valid;
  logic             calc_done;
  logic             dp_enable;
  logic             dp_reset;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] result_count;
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
  logic [31:0]      timeout_cycles;
  logic             error;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  acq_sequencer #(.CNT_W(CNT_W), .CLR_W(CLR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_results  (num_results),
    .clear_cycles (clear_cycles),
    .result_valid (result_valid),
    .calc_done    (calc_done),
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
    .timeout_cycles (timeout_cycles),
    .error          (error),
`endif
    .dp_enable    (dp_enable),
    .dp_reset     (dp_reset),
    .busy         (busy),
    .done         (done),
    .result_count (result_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // cc/n: clear_cycles/num_results; extra: strobes beyond n inside the run;
  // calc_off: calc_done rises this many cycles after DRAIN entry (may be
  // negative); kill_kind 0 none, 1 abort+start edge, 2 reset, at cycle
  // kill_at (negative: right after the (-kill_at)-th counted strobe).
  task automatic run_case(input int cc, input int n, input int extra, input int calc_off,
                          input int kill_kind, input int kill_at);
    bit   strb [MAXC];
    bit   stv  [MAXC];
    int   s_pos[$];
    int   len, pos, u, drain_c, v, done_c, kc, t_end, lim, m, cnt;
    logic [3:0] exp_f;

    len = (cc == 0) ? 1 : cc;
    for (int i = 0; i < MAXC; i++) begin
      strb[i] = (i <= len) && ($urandom_range(0, 1) == 1);
      stv[i]  = 1'b0;
    end
    pos = len + 1 + int'($urandom_range(0, 2));
    for (int i = 0; i < n + extra; i++) begin
      strb[pos] = 1'b1;
      s_pos.push_back(pos);
      pos += 1 + int'($urandom_range(0, 3));
    end
    u = (n > 0) ? s_pos[n-1] : len;
    for (int i = u + 1; i < MAXC; i++)
      if ($urandom_range(0, 3) == 0) strb[i] = 1'b1;
    drain_c = u + 1;
    v = drain_c + calc_off;
    if (v < 0) v = 0;
    done_c = ((v > drain_c) ? v : drain_c) + 1;
    kc = MAXC;
    if (kill_kind != 0) kc = (kill_at < 0) ? s_pos[-kill_at - 1] + 1 : kill_at;
    t_end = ((kill_kind != 0) ? kc : done_c) + 3;

    stv[0] = 1'b1;
    lim = (done_c - 2 < kc - 2) ? done_c - 2 : kc - 2;
    for (int i = 1; i <= lim; i++) stv[i] = ($urandom_range(0, 1) == 1);
    if (kill_kind == 1)
      for (int i = kc; i < MAXC; i++) stv[i] = 1'b1;

    reset = 1'b0; abort = 1'b0; start = 1'b0; result_valid = 1'b0; calc_done = 1'b0;
    num_results  = CNT_W'(n);
    clear_cycles = CLR_W'(cc);
    @(posedge clk); #1;
    for (int k = 0; k <= t_end; k++) begin
      if (k >= 1) begin
        if (k > kc) begin
          exp_f = 4'b0000;
          m = (kill_kind == 1) ? kc : -1;
        end else begin
          exp_f = {k <= len, (k >= len + 1) && (k <= u), k < done_c, k >= done_c};
          m = k;
        end
        cnt = 0;
        if (m >= 0)
          for (int c = len + 1; c <= ((m - 1 < u) ? m - 1 : u); c++)
            if (strb[c]) cnt++;
        chk($sformatf("flags{rst,en,busy,done}@%0d", k),
            64'({dp_reset, dp_enable, busy, done}), 64'(exp_f));
        chk($sformatf("count@%0d", k), 64'(result_count), 64'(cnt));
      end
      start        = stv[k];
      result_valid = strb[k];
      calc_done    = (k >= v);
      abort        = (kill_kind == 1) && (k == kc);
      reset        = (kill_kind == 2) && (k == kc);
      @(posedge clk); #1;
    end
    reset = 1'b0; abort = 1'b0; start = 1'b0; result_valid = 1'b0; calc_done = 1'b0;
  endtask

`ifdef ACQ_SEQUENCER_WATCHDOG_EN
  task automatic wd_case(input int to);
    int len, done_c;
    len = 2;
    clear_cycles = CLR_W'(len);
    num_results  = CNT_W'(5);
    timeout_cycles = 32'(to);
    start = 1'b0; result_valid = 1'b0; calc_done = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    done_c = (to != 0) ? len + 1 + to : MAXC;
    for (int k = 1; k <= len + 30; k++) begin
      @(posedge clk); #1;
      chk($sformatf("wd_en@%0d", k), 64'(dp_enable), 64'((k >= len + 1) && (k < done_c)));
      chk($sformatf("wd_done@%0d", k), 64'(done), 64'(k >= done_c));
      chk($sformatf("wd_error@%0d", k), 64'(error), 64'(k >= done_c));
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("wd_abort_busy", 64'({busy, done}), 64'(0));
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL sim_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int kind, ka;
    reset = 1'b1; start = 1'b0; abort = 1'b0; result_valid = 1'b0; calc_done = 1'b0;
    num_results = '0; clear_cycles = '0;
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
    timeout_cycles = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 64'({dp_reset, dp_enable, busy, done}), 64'(0));
    chk("reset_count", 64'(result_count), 64'(0));
`ifdef ACQ_SEQUENCER_WATCHDOG_EN
    chk("reset_error", 64'(error), 64'(0));
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_flags", 64'({dp_reset, dp_enable, busy, done}), 64'(0));

    run_case(3, 5, 0,  3, 0, 0);   // normal run, calc_done 4 cycles after last strobe
    run_case(3, 5, 3,  1, 0, 0);   // 8 strobes for 5 results
    run_case(0, 0, 0,  2, 0, 0);   // no results, minimum clear
    run_case(0, 0, 0, -3, 0, 0);   // calc_done already high on DRAIN entry
    run_case(2, 5, 0,  2, 1, -3);  // abort + start edge with count 3
    run_case(2, 6, 0,  2, 2, -3);  // reset in RUN with count 3
    run_case(1, 4, 1,  1, 0, 0);   // clean run after reset
    run_case(5, 1, 0,  0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      kind = int'($urandom_range(0, 5));
      kind = (kind == 4) ? 1 : (kind == 5) ? 2 : 0;
      ka   = int'($urandom_range(2, 14));
      run_case(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 6)) - 2, kind, ka);
    end

`ifdef ACQ_SEQUENCER_WATCHDOG_EN
    wd_case(20);
    wd_case(0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
